// File: rtl/ltc2324_pkg.sv
// ============================================================================
// Module      : ltc2324_pkg
// Description : Shared types and constants for the LTC2324 quad-ADC
//               controller: FSM state encoding, channel and word geometry,
//               and the minimum legal sample-period expression.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ltc2324_pkg;

  // Channel count and sample geometry of the LTC2324-16
  localparam int NUM_CH       = 4;
  localparam int DATA_W       = 16;
  // sck runs at clk_100m / SCK_DIV (low half then high half of each bit)
  localparam int SCK_DIV      = 4;
  // Clock cycles spent in SHIFT for one full word on every lane
  localparam int SHIFT_CYCLES = DATA_W * SCK_DIV;
  // Width of the test-pattern frame counter (word minus 2-bit channel tag)
  localparam int FRAME_CNT_W  = DATA_W - 2;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CNV   = 3'd1,
    ST_CONV  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  // Shortest frame: cnv pulse + conversion wait + shift + DONE + one HOLD cycle
  function automatic int min_period(input int cnv_high, input int conv_wait);
    return cnv_high + conv_wait + SHIFT_CYCLES + 2;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ltc2324_shift_rx.sv
// ============================================================================
// Module      : ltc2324_shift_rx
// Description : One MSB-first serial-to-parallel shift register for a single
//               ADC data lane. Synchronous clear has priority over capture.
//               The next-state value is exported so the parent can latch the
//               completed word on the same edge that shifts in the last bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ltc2324_shift_rx
  import ltc2324_pkg::*;
(
  input  logic              clk_100m,
  input  logic              rst,
  input  logic              clr,
  input  logic              cap_en,
  input  logic              sdo_bit,
  output logic [DATA_W-1:0] shift_next
);

  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;

  // Next value: clear at frame start, otherwise shift in one bit on capture
  always_comb begin
    shift_d = shift_q;
    if (clr) begin
      shift_d = '0;
    end else if (cap_en) begin
      shift_d = {shift_q[DATA_W-2:0], sdo_bit};
    end
  end

  // Shift register storage
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign shift_next = shift_d;

endmodule

`default_nettype wire

// File: rtl/ltc2324_ctrl.sv
// ============================================================================
// Module      : ltc2324_ctrl
// Description : Frame sequencer for the LTC2324-16 quad simultaneous-sampling
//               ADC. Generates cnv and sck (clk_100m/4), deserialises four
//               sdo lanes MSB first and presents one word per channel with a
//               single-cycle data_valid strobe every SAMPLE_PERIOD cycles.
//               Build option: define LTC2324_TEST_PATTERN_EN to replace the
//               captured data with {channel, 14-bit frame counter} words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ltc2324_ctrl
  import ltc2324_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 200,
  parameter int CNV_HIGH      = 2,
  parameter int CONV_WAIT     = 45
)
(
  input  logic              clk_100m,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] sdo,
  output logic              cnv,
  output logic              sck,
  output logic              busy,
  output logic [DATA_W-1:0] data_ch0,
  output logic [DATA_W-1:0] data_ch1,
  output logic [DATA_W-1:0] data_ch2,
  output logic [DATA_W-1:0] data_ch3,
  output logic              data_valid
);

  // Phase counter must reach the longest of the three timed states
  localparam int PHASE_MAX = max_int(max_int(CNV_HIGH, CONV_WAIT), SHIFT_CYCLES);
  localparam int PHASE_W   = $clog2(PHASE_MAX);
  localparam int PER_W     = $clog2(SAMPLE_PERIOD);

  localparam logic [PHASE_W-1:0] PH_CNV_LAST   = PHASE_W'(CNV_HIGH - 1);
  localparam logic [PHASE_W-1:0] PH_CONV_LAST  = PHASE_W'(CONV_WAIT - 1);
  localparam logic [PHASE_W-1:0] PH_SHIFT_LAST = PHASE_W'(SHIFT_CYCLES - 1);
  localparam logic [PER_W-1:0]   PER_LAST      = PER_W'(SAMPLE_PERIOD - 1);

  // A period too short to fit one complete frame is a configuration error
  if (SAMPLE_PERIOD < min_period(CNV_HIGH, CONV_WAIT) || CNV_HIGH < 1 || CONV_WAIT < 1)
  begin : g_period_check
    $error("ltc2324_ctrl: SAMPLE_PERIOD=%0d too short (min %0d) or zero-length phase",
           SAMPLE_PERIOD, min_period(CNV_HIGH, CONV_WAIT));
  end

  // ---------------------------------------------------------------- state
  state_e             state_q;
  state_e             state_d;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic [PER_W-1:0]   per_q;
  logic [PER_W-1:0]   per_d;

  logic               frame_start;
  logic               cap_en;

  // ---------------------------------------------------------------- outputs
  logic               cnv_q, cnv_d;
  logic               sck_q, sck_d;
  logic               busy_q, busy_d;
  logic               dv_q, dv_d;
  logic [DATA_W-1:0]  data_q [NUM_CH];
  logic [DATA_W-1:0]  data_d [NUM_CH];
  logic [DATA_W-1:0]  shift_next [NUM_CH];

`ifdef LTC2324_TEST_PATTERN_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;
`endif

  // State register: FSM state, in-state phase counter, period counter
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      per_q   <= per_d;
    end
  end

  // Next-state logic; enable is only consulted in IDLE and at the HOLD exit,
  // so dropping it mid-frame lets the current frame finish
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    per_d   = per_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        per_d   = '0;
        if (enable) state_d = ST_CNV;
      end
      ST_CNV: begin
        if (phase_q == PH_CNV_LAST) begin
          state_d = ST_CONV;
          phase_d = '0;
        end
      end
      ST_CONV: begin
        if (phase_q == PH_CONV_LAST) begin
          state_d = ST_SHIFT;
          phase_d = '0;
        end
      end
      ST_SHIFT: begin
        if (phase_q == PH_SHIFT_LAST) begin
          state_d = ST_DONE;
          phase_d = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_HOLD;
        phase_d = '0;
      end
      ST_HOLD: begin
        phase_d = '0;
        if (per_q == PER_LAST) state_d = enable ? ST_CNV : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        per_d   = '0;
      end
    endcase
    // Period counter is 0 in the first CNV cycle of every frame
    if (state_d == ST_CNV && state_q != ST_CNV) per_d = '0;
  end

  // Frame start clears the shift registers; capture on the edge ending the
  // last (sck-high) cycle of each bit
  assign frame_start = (state_d == ST_CNV) && (state_q != ST_CNV);
  assign cap_en      = (state_q == ST_SHIFT) && (phase_q[1:0] == 2'b11);

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    cnv_d  = (state_d == ST_CNV);
    sck_d  = (state_d == ST_SHIFT) && phase_d[1];
    busy_d = (state_d == ST_CNV) || (state_d == ST_CONV) ||
             (state_d == ST_SHIFT) || (state_d == ST_DONE);
    dv_d   = (state_d == ST_DONE);
`ifdef LTC2324_TEST_PATTERN_EN
    frame_cnt_d = dv_d ? frame_cnt_q + 1'b1 : frame_cnt_q;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      data_d[i] = data_q[i];
      if (dv_d) begin
`ifdef LTC2324_TEST_PATTERN_EN
        data_d[i] = {2'(i), frame_cnt_q};
`else
        // Latch the post-shift value: the last bit enters on this same edge
        data_d[i] = shift_next[i];
`endif
      end
    end
  end

  // Output registers
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      cnv_q  <= 1'b0;
      sck_q  <= 1'b0;
      busy_q <= 1'b0;
      dv_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) data_q[i] <= '0;
`ifdef LTC2324_TEST_PATTERN_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      cnv_q  <= cnv_d;
      sck_q  <= sck_d;
      busy_q <= busy_d;
      dv_q   <= dv_d;
      for (int i = 0; i < NUM_CH; i++) data_q[i] <= data_d[i];
`ifdef LTC2324_TEST_PATTERN_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  // One deserialiser per ADC lane
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ltc2324_shift_rx u_rx (
      .clk_100m   (clk_100m),
      .rst        (rst),
      .clr        (frame_start),
      .cap_en     (cap_en),
      .sdo_bit    (sdo[g]),
      .shift_next (shift_next[g])
    );
  end

  assign cnv        = cnv_q;
  assign sck        = sck_q;
  assign busy       = busy_q;
  assign data_valid = dv_q;
  assign data_ch0   = data_q[0];
  assign data_ch1   = data_q[1];
  assign data_ch2   = data_q[2];
  assign data_ch3   = data_q[3];

endmodule

`default_nettype wire

// File: tb/tb_ltc2324_ctrl.sv
// ============================================================================
// Module      : tb_ltc2324_ctrl
// Description : Self-checking bench for ltc2324_ctrl. An ADC lane model
//               serves programmed words on sdo; expected words are queued at
//               each cnv rising edge and compared at data_valid. Frame timing
//               (cnv period/width, sck count/period, data_valid latency),
//               enable drop and mid-frame reset are checked as well.
//               Honours LTC2324_TEST_PATTERN_EN for the expected data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ltc2324_ctrl;

  localparam int SP        = 200;
  localparam int CNV_HIGH  = 2;
  localparam int CONV_WAIT = 45;
  // First cnv cycle to data_valid cycle: CNV + CONV + SHIFT (cycle 112 if the
  // first cnv cycle is counted as cycle 1)
  localparam int DV_LAT    = CNV_HIGH + CONV_WAIT + 64;

  logic        clk_100m = 1'b0;
  logic        rst      = 1'b1;
  logic        enable   = 1'b0;
  logic [3:0]  sdo      = 4'h0;
  logic        cnv, sck, busy, data_valid;
  logic [15:0] data_ch0, data_ch1, data_ch2, data_ch3;

  ltc2324_ctrl #(
    .SAMPLE_PERIOD (SP),
    .CNV_HIGH      (CNV_HIGH),
    .CONV_WAIT     (CONV_WAIT)
  ) dut (
    .clk_100m   (clk_100m),
    .rst        (rst),
    .enable     (enable),
    .sdo        (sdo),
    .cnv        (cnv),
    .sck        (sck),
    .busy       (busy),
    .data_ch0   (data_ch0),
    .data_ch1   (data_ch1),
    .data_ch2   (data_ch2),
    .data_ch3   (data_ch3),
    .data_valid (data_valid)
  );

  always #5 clk_100m = ~clk_100m;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          dv_cnt = 0;
  int          rise_cnt = 0;
  int          last_rise = -1;
  int          last_sck = -1;
  int          sck_rises = 0;
  bit          period_chk = 1'b0;
  logic        cnv_prev = 1'b0;
  logic        sck_prev = 1'b0;
  logic [15:0] words [4];
  logic [63:0] exp_q [$];
  logic [63:0] last_exp = '0;
  logic [13:0] tp_cnt = '0;
  logic [63:0] pats [5];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ADC lane model: bit index advances on each sck falling edge, restarts on cnv
  int   bit_idx = 0;
  logic sck_m = 1'b0;
  always @(negedge clk_100m) begin
    if (cnv) bit_idx = 0;
    else if (sck_m && !sck) bit_idx++;
    sck_m = sck;
    for (int i = 0; i < 4; i++) sdo[i] = (bit_idx < 16) ? words[i][15 - bit_idx] : 1'b0;
  end

  // Monitor / scoreboard, sampled 1 ns after the active edge
  always @(posedge clk_100m) begin
    logic [63:0] e;
    #1;
    cyc++;
    if (rst) begin
      last_rise = -1;
      last_sck  = -1;
      cnv_prev  = 1'b0;
      sck_prev  = 1'b0;
    end else begin
      if (cnv && !cnv_prev) begin
        if (period_chk && last_rise >= 0) check("cnv_period", 64'(cyc - last_rise), 64'(SP));
        last_rise = cyc;
        rise_cnt++;
        sck_rises = 0;
        last_sck  = -1;
`ifdef LTC2324_TEST_PATTERN_EN
        exp_q.push_back({2'd3, tp_cnt, 2'd2, tp_cnt, 2'd1, tp_cnt, 2'd0, tp_cnt});
        tp_cnt = tp_cnt + 14'd1;
`else
        exp_q.push_back({words[3], words[2], words[1], words[0]});
`endif
      end
      if (!cnv && cnv_prev && last_rise >= 0)
        check("cnv_width", 64'(cyc - last_rise), 64'(CNV_HIGH));
      if (sck && !sck_prev) begin
        if (last_sck >= 0) check("sck_period", 64'(cyc - last_sck), 64'd4);
        last_sck = cyc;
        sck_rises++;
      end
      if (data_valid) begin
        dv_cnt++;
        check("dv_latency", 64'(cyc - last_rise), 64'(DV_LAT));
        check("sck_count", 64'(sck_rises), 64'd16);
        check("busy_at_dv", 64'(busy), 64'd1);
        if (exp_q.size() == 0) begin
          check("dv_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          last_exp = e;
          check("data_ch0", 64'(data_ch0), 64'(e[15:0]));
          check("data_ch1", 64'(data_ch1), 64'(e[31:16]));
          check("data_ch2", 64'(data_ch2), 64'(e[47:32]));
          check("data_ch3", 64'(data_ch3), 64'(e[63:48]));
        end
      end
      cnv_prev = cnv;
      sck_prev = sck;
    end
  end

  task automatic set_words(input logic [63:0] p);
    for (int i = 0; i < 4; i++) words[i] = p[16*i +: 16];
  endtask

  task automatic wait_dv(input int target, input int budget);
    int t = 0;
    while (dv_cnt < target && t < budget) begin
      @(negedge clk_100m);
      t++;
    end
    check("wait_dv", 64'(dv_cnt >= target), 64'd1);
  endtask

  task automatic wait_sck(input int budget);
    int t = 0;
    while (!sck && t < budget) begin
      @(negedge clk_100m);
      t++;
    end
    check("wait_sck", 64'(sck), 64'd1);
  endtask

  initial begin
    int rc;
    int d0;
    pats[0] = {16'hFFFF, 16'h8000, 16'h0001, 16'hA5C3};
    pats[1] = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    pats[2] = {16'h5555, 16'hAAAA, 16'hFFFF, 16'h0000};
    pats[3] = {16'hF0F0, 16'h0F0F, 16'h7FFE, 16'h8001};
    pats[4] = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    set_words(pats[0]);

    // Reset state
    repeat (4) @(negedge clk_100m);
    check("rst_cnv", 64'(cnv), 64'd0);
    check("rst_sck", 64'(sck), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dv", 64'(data_valid), 64'd0);
    check("rst_data", {data_ch3, data_ch2, data_ch1, data_ch0}, 64'd0);

    // Five continuous frames with a different pattern each frame
    period_chk = 1'b1;
    rst    = 1'b0;
    enable = 1'b1;
    for (int f = 0; f < 5; f++) begin
      if (f > 0) set_words(pats[f]);
      wait_dv(f + 1, SP + 150);
    end
    enable = 1'b0;
    repeat (2 * SP) @(negedge clk_100m);
    period_chk = 1'b0;
    check("frames_cnv_count", 64'(rise_cnt), 64'd5);
    check("idle_cnv", 64'(cnv), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_hold_data", {data_ch3, data_ch2, data_ch1, data_ch0}, last_exp);

    // enable dropped during SHIFT: frame completes, then idle
    set_words(64'h0123_4567_89AB_CDEF);
    d0 = dv_cnt;
    enable = 1'b1;
    wait_sck(200);
    enable = 1'b0;
    rc = rise_cnt;
    wait_dv(d0 + 1, 150);
    repeat (SP + 50) @(negedge clk_100m);
    check("drop_no_cnv", 64'(rise_cnt), 64'(rc));
    check("drop_cnv", 64'(cnv), 64'd0);
    check("drop_busy", 64'(busy), 64'd0);

    // Reset pulsed during SHIFT: aborted frame yields no data_valid
    set_words(64'hCAFE_BEEF_1357_2468);
    enable = 1'b1;
    wait_sck(200);
    d0 = dv_cnt;
    rst = 1'b1;
    exp_q.delete();
    tp_cnt = '0;
    @(negedge clk_100m);
    check("mrst_cnv", 64'(cnv), 64'd0);
    check("mrst_sck", 64'(sck), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_dv", 64'(data_valid), 64'd0);
    check("mrst_data", {data_ch3, data_ch2, data_ch1, data_ch0}, 64'd0);
    rst = 1'b0;
    @(negedge clk_100m);
    check("cnv_after_rst", 64'(cnv), 64'd1);
    check("no_dv_aborted", 64'(dv_cnt), 64'(d0));
    wait_dv(d0 + 1, 150);
    enable = 1'b0;
    repeat (SP + 50) @(negedge clk_100m);
    check("end_idle_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
